// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencing controller.
//   Owns the fetch PC and issues one-outstanding req/ack reads to
//   instruction memory. Fetched words go into a 2-entry buffer toward decode.
//   Redirects from execute flush that buffer and squash any wrong-path
//   request that is still in flight.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   PCSrc_E, PCTarget_E,       redirect select (01 target, 10 jalr,
//   PCJALR_E                   00/11 sequential) and the two redirect targets
//   Stall_D                    decode cannot accept the buffer head this cycle
//   imem_req, imem_addr        memory read request and its address
//   imem_ack, imem_rdata       read completion and returned instruction
//   Valid_F, Instr_F, PC_F,    buffer head toward decode (registered storage)
//   PCPlus4_F
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrc_E,
  input  logic [31:0] PCTarget_E,
  input  logic [31:0] PCJALR_E,
  input  logic        Stall_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        Valid_F,
  output logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PCPlus4_F
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // no request outstanding
    S_WAIT  = 2'd1,  // request to fetch_pc outstanding
    S_DRAIN = 2'd2   // wrong-path request outstanding, data will be dropped
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;

  logic [31:0] fifo_instr_q [FIFO_DEPTH];
  logic [31:0] fifo_pc_q    [FIFO_DEPTH];

  logic        redirect;
  logic [31:0] tgt;
  logic        head_valid;
  logic        pop;
  logic        space;
  logic        push;
  logic        req_int;

  assign redirect = (PCSrc_E == 2'b01) || (PCSrc_E == 2'b10);
  assign tgt      = (PCSrc_E == 2'b10) ? PCJALR_E : PCTarget_E;

  // Head is hidden during reset so decode never sees stale entries.
  assign head_valid = (count_q != 2'd0) && !rst;
  assign pop        = head_valid && !Stall_D;
  // A pop this cycle frees a slot in time for a same-cycle push.
  assign space      = (count_q < 2'(FIFO_DEPTH)) || pop;

  // Fetch FSM: next state, request and push decision.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    req_int      = 1'b0;
    imem_addr    = fetch_pc_q;
    push         = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_int = space && !redirect;
        if (redirect) begin
          fetch_pc_d = tgt;
        end else if (space) begin
          if (imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req_int = 1'b1;
        if (redirect) begin
          fetch_pc_d = tgt;
          if (imem_ack) begin
            state_d = S_IDLE;
          end else begin
            // Keep presenting the old address until memory completes it.
            drain_addr_d = fetch_pc_q;
            state_d      = S_DRAIN;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_IDLE;
        end
      end
      S_DRAIN: begin
        req_int   = 1'b1;
        imem_addr = drain_addr_q;
        if (redirect) begin
          fetch_pc_d = tgt;
        end
        if (imem_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    imem_req = req_int && !rst;
  end

  // Buffer bookkeeping; a redirect empties the buffer outright.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d = count_q + 2'(push) - 2'(pop);
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign Valid_F   = head_valid;
  assign Instr_F   = fifo_instr_q[rd_ptr_q];
  assign PC_F      = fifo_pc_q[rd_ptr_q];
  assign PCPlus4_F = fifo_pc_q[rd_ptr_q] + 32'd4;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl.
//   A transaction-level model (queue of fetched words, fetch PC, one
//   outstanding-request record with a squash flag) predicts every output each
//   cycle; a compare process checks the DUT on the falling edge. Directed
//   sequences pin the model with hand-computed literals, then randomized
//   redirects, stalls, memory latencies and resets run against the model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] XMASK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  PCSrc_E = 2'b00;
  logic [31:0] PCTarget_E = 32'h0;
  logic [31:0] PCJALR_E = 32'h0;
  logic        Stall_D = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        Valid_F;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] PCPlus4_F;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrc_E    (PCSrc_E),
    .PCTarget_E (PCTarget_E),
    .PCJALR_E   (PCJALR_E),
    .Stall_D    (Stall_D),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Valid_F    (Valid_F),
    .Instr_F    (Instr_F),
    .PC_F       (PC_F),
    .PCPlus4_F  (PCPlus4_F)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [63:0] mq[$];          // {instr, pc} words delivered but not yet taken
  logic [31:0] m_pc = RST_PC;  // next address to fetch
  bit          m_busy = 0;     // a memory request is outstanding
  logic [31:0] m_busy_addr = 32'h0;
  bit          m_wrong = 0;    // outstanding request was overtaken by a redirect

  function automatic bit m_redirect();
    return (PCSrc_E == 2'b01) || (PCSrc_E == 2'b10);
  endfunction

  function automatic logic [31:0] m_tgt();
    return (PCSrc_E == 2'b10) ? PCJALR_E : PCTarget_E;
  endfunction

  function automatic bit m_valid();
    return !rst && (mq.size() > 0);
  endfunction

  function automatic bit m_req();
    if (rst) return 1'b0;
    if (m_busy) return 1'b1;
    return ((mq.size() < 2) || (m_valid() && !Stall_D)) && !m_redirect();
  endfunction

  function automatic logic [31:0] m_addr();
    return m_busy ? m_busy_addr : m_pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the inputs of the cycle.
  task automatic model_update();
    bit req;
    bit pop;
    if (rst) begin
      mq.delete();
      m_pc    = RST_PC;
      m_busy  = 0;
      m_wrong = 0;
    end else begin
      req = m_req();
      pop = m_valid() && !Stall_D;
      if (m_redirect()) begin
        mq.delete();
        if (m_busy && !imem_ack) begin
          m_wrong = 1;
        end else begin
          m_busy  = 0;
          m_wrong = 0;
        end
        m_pc = m_tgt();
      end else begin
        if (pop) void'(mq.pop_front());
        if (req && imem_ack) begin
          if (!m_wrong) begin
            mq.push_back({imem_rdata, m_addr()});
            m_pc = m_addr() + 32'd4;
          end
          m_busy  = 0;
          m_wrong = 0;
        end else if (req && !m_busy) begin
          m_busy      = 1;
          m_busy_addr = m_pc;
          m_wrong     = 0;
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid()) begin
        chk("valid", {31'b0, Valid_F}, 32'd1);
        chk("pc_f", PC_F, mq[0][31:0]);
        chk("instr_f", Instr_F, mq[0][63:32]);
        chk("pcplus4_f", PCPlus4_F, mq[0][31:0] + 32'd4);
      end else begin
        chk("valid", {31'b0, Valid_F}, 32'd0);
      end
      if (m_req()) begin
        chk("req", {31'b0, imem_req}, 32'd1);
        chk("addr", imem_addr, m_addr());
      end else begin
        chk("req", {31'b0, imem_req}, 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  int wait_cnt = 0;
  int cur_lat  = 0;

  // One cycle: cross the edge, update the model, apply new inputs, settle.
  // lat < 0 picks a random latency of 0..3 cycles per request.
  task automatic cycle(input bit r, input logic [1:0] src, input logic [31:0] t,
                       input logic [31:0] j, input bit st, input int lat);
    bit req;
    bit ack;
    @(posedge clk);
    model_update();
    #1;
    rst        = r;
    PCSrc_E    = src;
    PCTarget_E = t;
    PCJALR_E   = j;
    Stall_D    = st;
    req = m_req();
    if (!req) begin
      wait_cnt = 0;
      ack      = 0;
    end else begin
      if (wait_cnt == 0) cur_lat = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      ack      = (wait_cnt >= cur_lat);
      wait_cnt = ack ? 0 : wait_cnt + 1;
    end
    imem_ack   = ack;
    imem_rdata = ack ? (m_addr() ^ XMASK) : $urandom;
    #1;
  endtask

  function automatic logic [31:0] rand_tgt();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'hFFFF_FFFC;
    if (sel == 1) return 32'hFFFF_FFF8;
    if (sel == 2) return $urandom;
    return $urandom & 32'h0000_FFFC;
  endfunction

  initial begin
    logic [1:0]  src;
    int          roll;
    logic [31:0] exp_pc;

    // Reset: outputs quiet.
    cycle(1, 2'b00, 0, 0, 0, 0);
    cycle(1, 2'b00, 0, 0, 0, 0);
    chk("lit_rst_valid", {31'b0, Valid_F}, 32'd0);
    chk("lit_rst_req", {31'b0, imem_req}, 32'd0);

    // Zero-latency memory, no stalls: first head one cycle after reset.
    cycle(0, 2'b00, 0, 0, 0, 0);
    chk("lit_c0_valid", {31'b0, Valid_F}, 32'd0);
    chk("lit_c0_addr", imem_addr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 2'b00, 0, 0, 0, 0);
      exp_pc = 32'(k * 4);
      chk("lit_seq_valid", {31'b0, Valid_F}, 32'd1);
      chk("lit_seq_pc", PC_F, exp_pc);
      chk("lit_seq_instr", Instr_F, exp_pc ^ XMASK);
    end

    // Decode stall fills the buffer and stops requests.
    for (int k = 0; k < 4; k++) cycle(0, 2'b00, 0, 0, 1, 0);
    chk("lit_stall_req", {31'b0, imem_req}, 32'd0);
    chk("lit_stall_pc", PC_F, 32'h10);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 2'b00, 0, 0, 0, 0);
      chk("lit_release_pc", PC_F, 32'h10 + 32'(k * 4));
    end

    // JALR redirect in a cycle that also pops and acks.
    cycle(0, 2'b10, 0, 32'h200, 0, 0);
    chk("lit_jalr_pop_pc", PC_F, 32'h1C);
    chk("lit_jalr_req", {31'b0, imem_req}, 32'd0);
    cycle(0, 2'b00, 0, 0, 0, 0);
    chk("lit_jalr_valid0", {31'b0, Valid_F}, 32'd0);
    chk("lit_jalr_addr", imem_addr, 32'h200);
    cycle(0, 2'b00, 0, 0, 0, 0);
    chk("lit_jalr_pc", PC_F, 32'h200);
    chk("lit_jalr_plus4", PCPlus4_F, 32'h204);

    // Redirect while waiting: old address held until its ack, then target.
    cycle(1, 2'b00, 0, 0, 0, 3);
    cycle(0, 2'b00, 0, 0, 0, 3);
    cycle(0, 2'b01, 32'h100, 0, 0, 3);
    chk("lit_drain_addr1", imem_addr, 32'h0);
    cycle(0, 2'b00, 0, 0, 0, 3);
    chk("lit_drain_addr2", imem_addr, 32'h0);
    chk("lit_drain_valid", {31'b0, Valid_F}, 32'd0);
    cycle(0, 2'b00, 0, 0, 0, 3);
    cycle(0, 2'b00, 0, 0, 0, 3);
    chk("lit_drain_newaddr", imem_addr, 32'h100);
    for (int k = 0; k < 3; k++) cycle(0, 2'b00, 0, 0, 0, 3);
    chk("lit_drain_notyet", {31'b0, Valid_F}, 32'd0);
    cycle(0, 2'b00, 0, 0, 0, 3);
    chk("lit_drain_pc", PC_F, 32'h100);

    // Randomized traffic: redirects, reserved select, stalls, latency, resets.
    for (int n = 0; n < 4000; n++) begin
      roll = $urandom_range(0, 99);
      if (roll < 80) src = 2'b00;
      else if (roll < 87) src = 2'b01;
      else if (roll < 94) src = 2'b10;
      else src = 2'b11;
      cycle(($urandom_range(0, 99) == 0), src, rand_tgt(), rand_tgt(),
            ($urandom_range(0, 99) < 30), (n < 1000) ? 0 : -1);
    end
    cycle(0, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
